shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Sequencer for the 8-bit load/shift-left register: accepts a word plus a shift amount over a valid/ready handshake, parallel-loads the register, then issues N left shifts while streaming the MSB out serially.
- Presents the shifted parallel result over a second valid/ready handshake.
- Sits between a word producer (bus or CPU-side logic) and a serial consumer, e.g. a bit-serial transmitter.

Parameters:
- WIDTH, 8, data/register width in bits
- CW, 4, shift-count width (enough to hold 0..WIDTH)

Ports:
- CLK  in  1  clock, all state changes on rising edge
- Clr  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a word
- in_ready  out  1  controller can accept a word (IDLE only)
- in_data  in  WIDTH  word to load
- in_shamt  in  CW  number of left shifts, sampled at accept
- in_fill  in  1  bit shifted into LSB, sampled at accept
- abort  in  1  synchronous cancel of the current operation
- ser_valid  out  1  ser_bit is valid this cycle (one per shift)
- ser_bit  out  1  current register MSB, the bit being shifted out
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_data  out  WIDTH  register contents
- busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset (Clr=0, asynchronous):
  - State = IDLE; register = 0; count = 0; latched fill = 0.
  - Outputs: in_ready=1, ser_valid=0, out_valid=0, busy=0, ser_bit=0, out_data=0.
- Register control: the controller drives the register's select (0=load, 1=shift), load data, and fill bit.
  - The register has no hold mode. In IDLE and DONE, "hold" is done by loading its own output.
- IDLE:
  - in_ready=1. The load source is in_data when in_valid=1, otherwise the register output.
  - On an edge with in_valid&in_ready: register<=in_data, count<=min(in_shamt,WIDTH), fill latched.
  - Next state is SHIFT if the clamped count is nonzero, else DONE.
- SHIFT:
  - Select=shift; ser_valid=1; ser_bit=register[WIDTH-1].
  - Each edge shifts left with the latched fill into bit 0 and decrements count.
  - The edge at which count==1 moves to DONE.
  - Exactly N ser_valid cycles are produced, MSB first.
- DONE:
  - out_valid=1; out_data=register; the register holds.
  - On an edge with out_ready=1, go to IDLE. out_valid stays high until then.
  - No new input is accepted in the same cycle (in_ready=0).
- Latency: accept edge E0; shift edges E1..EN; out_valid high in the cycle after EN. With N=0, out_valid is high in the cycle after E0 and out_data=in_data.
- abort:
  - In SHIFT or DONE: next state IDLE, register keeps its current value, no out_valid.
  - In IDLE: ignored. abort has priority over accept, so no accept occurs while abort=1.
- Shift amounts above WIDTH clamp to WIDTH; the result is then all fill bits.
- out_data mirrors the register in every state. It is valid to sample only when out_valid=1.
- Asynchronous reset mid-operation: immediate return to the reset values. No partial output is retained.

Decomposition:
- Shared package: state encoding (IDLE, SHIFT, DONE) as constants; select-value constants (SEL_LOAD=0, SEL_SHIFT=1); WIDTH/CW defaults.
- One sub-module: shift_reg_core, a WIDTH-bit register with asynchronous active-low clear and load/shift-left select.
  - Instantiated once inside shift_seq_ctrl.
  - The FSM, counter and handshake logic stay in the top.

Test Plan:
- Reset then idle: Clr low for 2 cycles, release with in_valid=0 → in_ready=1, busy=0, out_valid=0, out_data=0x00 held for 10 cycles.
- Basic shift: in_data=0xA5, in_shamt=3, in_fill=1, out_ready=1 → ser_valid for exactly 3 cycles with ser_bit 1,0,1; out_valid one cycle later with out_data=0x2F; back to IDLE.
- Zero and clamp:
  - in_shamt=0, in_data=0x3C → no ser_valid; out_valid next cycle with 0x3C.
  - in_shamt=12, in_fill=0, in_data=0xFF → 8 serial ones; out_data=0x00.
- Output backpressure: 0x81 with shamt=1, fill=0 and out_ready=0 for 5 cycles → out_valid and out_data=0x02 stable, in_ready=0 and a new in_valid ignored; raising out_ready returns to IDLE after one edge.
- Abort: abort after 2 of 5 shifts of 0xF0 (fill 0) → IDLE next cycle, register=0xC0, no out_valid; abort asserted together with in_valid in IDLE → no accept.
- Asynchronous reset mid-shift: drop Clr between clock edges during SHIFT → outputs go to reset values immediately without a clock edge; a fresh transaction afterwards completes correctly.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the load/shift-left sequencer: state encoding,
// register select values and default widths.
package shift_seq_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CW    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic SEL_LOAD  = 1'b0;
    localparam logic SEL_SHIFT = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl_shift_reg_core.sv
// WIDTH-bit register with asynchronous active-low clear and a load/shift-left
// select; there is no hold mode, so callers hold by loading q back.
module shift_reg_core
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic [WIDTH-1:0] load_data,
    input  logic             fill,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (sel == SEL_SHIFT) begin
            q <= {q[WIDTH-2:0], fill};
        end else begin
            q <= load_data;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer: accepts a word and shift amount, issues N left shifts while
// streaming the MSB out, then presents the result over a valid/ready handshake.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
) (
    input  logic             CLK,
    input  logic             Clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CW-1:0]    in_shamt,
    input  logic             in_fill,
    input  logic             abort,
    output logic             ser_valid,
    output logic             ser_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             fill_q, fill_d;
    logic             reg_sel;
    logic [WIDTH-1:0] reg_load;
    logic [WIDTH-1:0] reg_q;
    logic [CW-1:0]    shamt_clamped;

    function automatic logic [CW-1:0] clamp_shamt(input logic [CW-1:0] s);
        return (s > CW'(WIDTH)) ? CW'(WIDTH) : s;
    endfunction

    assign shamt_clamped = clamp_shamt(in_shamt);

    shift_reg_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (CLK),
        .rst_n    (Clr),
        .sel      (reg_sel),
        .load_data(reg_load),
        .fill     (fill_q),
        .q        (reg_q)
    );

    always_ff @(posedge CLK or negedge Clr) begin
        if (!Clr) begin
            state_q <= IDLE;
            count_q <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        fill_d    = fill_q;
        reg_sel   = SEL_LOAD;
        reg_load  = reg_q;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                // abort outranks accept, so the register must not pick up in_data
                if (in_valid && !abort) begin
                    reg_load = in_data;
                    count_d  = shamt_clamped;
                    fill_d   = in_fill;
                    state_d  = (shamt_clamped != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    reg_sel = SEL_SHIFT;
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (abort || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ser_bit  = reg_q[WIDTH-1];
    assign out_data = reg_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a transaction model.
module tb_shift_seq_ctrl;

    localparam int W = 8;
    localparam int C = 4;

    logic         CLK       = 1'b0;
    logic         Clr       = 1'b0;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic [C-1:0] in_shamt  = '0;
    logic         in_fill   = 1'b0;
    logic         abort     = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, ser_valid, ser_bit, out_valid, busy;
    logic [W-1:0] out_data;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    shift_seq_ctrl #(.WIDTH(W), .CW(C)) dut (
        .CLK      (CLK),
        .Clr      (Clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .in_fill  (in_fill),
        .abort    (abort),
        .ser_valid(ser_valid),
        .ser_bit  (ser_bit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Register contents after k left shifts of d with fill f.
    function automatic logic [W-1:0] reg_after(input logic [W-1:0] d, input logic f, input int k);
        logic [W-1:0] m;
        if (k >= W) return {W{f}};
        m = (8'd1 << k) - 8'd1;
        return (d << k) | (f ? m : 8'd0);
    endfunction

    function automatic int clampn(input int s);
        return (s > W) ? W : s;
    endfunction

    // Transaction-level model: an active transaction has n shifts to make,
    // k already made, and then waits with its result until taken or aborted.
    bit           m_act = 1'b0;
    bit           m_res = 1'b0;
    logic [W-1:0] m_data = '0;
    logic         m_fill = 1'b0;
    int           m_n = 0;
    int           m_k = 0;
    logic [W-1:0] m_reg = '0;

    always @(posedge CLK or negedge Clr) begin
        if (!Clr) begin
            m_act <= 1'b0;
            m_res <= 1'b0;
            m_reg <= '0;
            m_k   <= 0;
            m_n   <= 0;
        end else if (!m_act) begin
            if (in_valid && !abort) begin
                m_act  <= 1'b1;
                m_data <= in_data;
                m_fill <= in_fill;
                m_n    <= clampn(int'(in_shamt));
                m_k    <= 0;
                m_res  <= (clampn(int'(in_shamt)) == 0);
            end
        end else if (!m_res) begin
            if (abort) begin
                m_act <= 1'b0;
                m_reg <= reg_after(m_data, m_fill, m_k);
            end else begin
                m_k <= m_k + 1;
                if (m_k + 1 == m_n) m_res <= 1'b1;
            end
        end else if (abort || out_ready) begin
            m_act <= 1'b0;
            m_res <= 1'b0;
            m_reg <= reg_after(m_data, m_fill, m_n);
        end
    end

    logic [W-1:0] exp_r;
    always @(negedge CLK) begin
        if (cmp_en) begin
            if (!m_act) begin
                chk("idle.in_ready", in_ready, 1);
                chk("idle.busy", busy, 0);
                chk("idle.ser_valid", ser_valid, 0);
                chk("idle.out_valid", out_valid, 0);
                chk("idle.out_data", out_data, m_reg);
            end else if (!m_res) begin
                exp_r = reg_after(m_data, m_fill, m_k);
                chk("shift.in_ready", in_ready, 0);
                chk("shift.busy", busy, 1);
                chk("shift.ser_valid", ser_valid, 1);
                chk("shift.ser_bit", ser_bit, exp_r[W-1]);
                chk("shift.out_valid", out_valid, 0);
                chk("shift.out_data", out_data, exp_r);
            end else begin
                chk("done.in_ready", in_ready, 0);
                chk("done.busy", busy, 1);
                chk("done.ser_valid", ser_valid, 0);
                chk("done.out_valid", out_valid, 1);
                chk("done.out_data", out_data, reg_after(m_data, m_fill, m_n));
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Launch one transaction from IDLE and stop at the first out_valid cycle.
    task automatic run_tx(input logic [W-1:0] d, input logic [C-1:0] s, input logic f,
                          input logic ordy, output int nser, output logic [15:0] bits,
                          output logic [W-1:0] res);
        bit got;
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = s;
        in_fill   = f;
        out_ready = ordy;
        cyc();
        in_valid = 1'b0;
        nser = 0;
        bits = '0;
        res  = '0;
        got  = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (out_valid) begin
                got = 1'b1;
                res = out_data;
            end else begin
                if (ser_valid) begin
                    nser++;
                    bits = {bits[14:0], ser_bit};
                end
                cyc();
            end
        end
        chk("tx_completed", got, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int           nser;
        logic [15:0]  bits;
        logic [W-1:0] res;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.ser_bit", ser_bit, 0);
        chk("rst.out_data", out_data, 8'h00);
        Clr    = 1'b1;
        cmp_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            chk("rst_idle.in_ready", in_ready, 1);
            chk("rst_idle.busy", busy, 0);
            chk("rst_idle.out_valid", out_valid, 0);
            chk("rst_idle.out_data", out_data, 8'h00);
            cyc();
        end

        run_tx(8'hA5, 4'd3, 1'b1, 1'b1, nser, bits, res);
        chk("basic.nser", nser, 3);
        chk("basic.bits", bits, 16'h0005);
        chk("basic.result", res, 8'h2F);
        cyc();
        chk("basic.back_idle", in_ready, 1);

        run_tx(8'h3C, 4'd0, 1'b0, 1'b1, nser, bits, res);
        chk("zero.nser", nser, 0);
        chk("zero.result", res, 8'h3C);
        cyc();

        run_tx(8'hFF, 4'd12, 1'b0, 1'b1, nser, bits, res);
        chk("clamp.nser", nser, 8);
        chk("clamp.bits", bits, 16'h00FF);
        chk("clamp.result", res, 8'h00);
        cyc();

        run_tx(8'h81, 4'd1, 1'b0, 1'b0, nser, bits, res);
        chk("bp.result", res, 8'h02);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_shamt = 4'd0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp.out_valid", out_valid, 1);
            chk("bp.out_data", out_data, 8'h02);
            chk("bp.in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("bp.release_idle", in_ready, 1);
        chk("bp.release_ov", out_valid, 0);

        in_valid = 1'b1;
        in_data  = 8'hF0;
        in_shamt = 4'd5;
        in_fill  = 1'b0;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("abort.before", out_data, 8'hC0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort.in_ready", in_ready, 1);
        chk("abort.busy", busy, 0);
        chk("abort.out_valid", out_valid, 0);
        chk("abort.reg", out_data, 8'hC0);

        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_shamt = 4'd2;
        cyc();
        chk("abort_idle.busy", busy, 0);
        chk("abort_idle.reg", out_data, 8'hC0);
        abort    = 1'b0;
        in_valid = 1'b0;
        cyc();

        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_shamt = 4'd5;
        in_fill  = 1'b0;
        cyc();
        in_valid = 1'b0;
        cyc();
        #2 Clr = 1'b0;
        #1;
        chk("arst.in_ready", in_ready, 1);
        chk("arst.busy", busy, 0);
        chk("arst.ser_valid", ser_valid, 0);
        chk("arst.out_valid", out_valid, 0);
        chk("arst.ser_bit", ser_bit, 0);
        chk("arst.out_data", out_data, 8'h00);
        @(posedge CLK);
        @(negedge CLK);
        Clr = 1'b1;
        cyc();
        run_tx(8'h3C, 4'd2, 1'b1, 1'b1, nser, bits, res);
        chk("post_rst.nser", nser, 2);
        chk("post_rst.bits", bits, 16'h0000);
        chk("post_rst.result", res, 8'hF3);
        cyc();

        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = W'($urandom);
            in_shamt  = C'($urandom_range(0, 15));
            in_fill   = ($urandom_range(0, 1) == 1);
            abort     = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 4) < 3);
            cyc();
        end
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (20) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
